// File: rtl/clk_rst_pkg.sv
// PLL reset / lock sequencer shared types and width helpers.
// Optional lock timeout is enabled by CLK_RST_SEQ_LOCK_TIMEOUT_EN.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_e;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync_2ff.sv
// Two-flop synchroniser, parametric width, synchronous active-low reset.
// Used by clk_rst_seq for the raw PLL LOCKED inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// PLL reset / lock sequencer: pulses PLL RST, filters LOCKED, releases domains in order.
// Define CLK_RST_SEQ_LOCK_TIMEOUT_EN to retry when lock never settles.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_PLL      = 2,
    parameter int NUM_DOM      = 4,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_FILTER  = 64,
    parameter int RELEASE_GAP  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CNT_W        = 8
) (
    input  logic               clk24_ref,
    input  logic               rst_n,
    input  logic [NUM_PLL-1:0] pll_locked,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               locked,
    output logic [CNT_W-1:0]   relock_cnt,
    output logic               timeout
);

    localparam int CW = cnt_bits(max3(RST_CYCLES, LOCK_FILTER, RELEASE_GAP));
    localparam int IW = cnt_bits(NUM_DOM);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      idx_q;
    logic               pll_rst_q;
    logic [NUM_DOM-1:0] dom_q;
    logic [NUM_DOM-1:0] dom_d;
    logic               locked_q;
    logic [CNT_W-1:0]   relock_q;
    logic [CNT_W-1:0]   relock_d;
    logic [NUM_PLL-1:0] locked_sync;
    logic               lock_ok;
    logic               filter_done;
    logic               lost;
    logic               tmo_hit;
    logic               restart;

    sync_2ff #(
        .WIDTH (NUM_PLL)
    ) u_sync (
        .clk_i  (clk24_ref),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_sync)
    );

    assign lock_ok     = &locked_sync;
    assign filter_done = (state_q == WAIT_LOCK) && lock_ok &&
                         (cnt_q == CW'(LOCK_FILTER - 1));
    assign lost        = !lock_ok && ((state_q == RELEASE) || (state_q == RUN));
    assign restart     = lost || tmo_hit;
    assign relock_d    = (relock_q == {CNT_W{1'b1}}) ? relock_q : relock_q + 1'b1;

    always_comb begin
        dom_d = dom_q;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (idx_q == IW'(i)) dom_d[i] = 1'b1;
        end
    end

`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
    localparam int TW = cnt_bits(LOCK_TIMEOUT);

    logic [TW-1:0] tcnt_q;
    logic          timeout_q;

    // Filter success takes priority over an expiring timeout.
    assign tmo_hit = (state_q == WAIT_LOCK) && !filter_done &&
                     (tcnt_q == TW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk24_ref) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= (state_q == WAIT_LOCK) ? tcnt_q + 1'b1 : '0;
            timeout_q <= tmo_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk24_ref) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            locked_q  <= 1'b0;
            relock_q  <= '0;
        end else if (restart) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            locked_q  <= 1'b0;
            relock_q  <= relock_d;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (filter_done) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (!lock_ok) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // One release per gap; the extra index slot is the final gap.
                    if (cnt_q == '0 && idx_q == IW'(NUM_DOM)) begin
                        state_q  <= RUN;
                        locked_q <= 1'b1;
                    end else begin
                        if (cnt_q == '0) dom_q <= dom_d;
                        if (cnt_q == CW'(RELEASE_GAP - 1)) begin
                            cnt_q <= '0;
                            idx_q <= idx_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    locked_q <= 1'b1;
                end
            endcase
        end
    end

    assign pll_rst    = {NUM_PLL{pll_rst_q}};
    assign dom_rst_n  = dom_q;
    assign locked     = locked_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: default instance plus a small-counter,
// short-timeout instance sharing clock, reset and lock inputs.
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pll_locked = 2'b11;

    logic [1:0] pll_rst_a, pll_rst_b;
    logic [3:0] dom_a, dom_b;
    logic       locked_a, locked_b;
    logic [7:0] relock_a;
    logic [1:0] relock_b;
    logic       timeout_a, timeout_b;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    clk_rst_seq dut_a (
        .clk24_ref  (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst_a),
        .dom_rst_n  (dom_a),
        .locked     (locked_a),
        .relock_cnt (relock_a),
        .timeout    (timeout_a)
    );

    clk_rst_seq #(
        .LOCK_TIMEOUT (100),
        .CNT_W        (2)
    ) dut_b (
        .clk24_ref  (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst_b),
        .dom_rst_n  (dom_b),
        .locked     (locked_b),
        .relock_cnt (relock_b),
        .timeout    (timeout_b)
    );

    function automatic logic [15:0] obs(input bit s);
        if (!s) return {pll_rst_a, dom_a, locked_a, relock_a, timeout_a};
        return {pll_rst_b, dom_b, locked_b, 6'd0, relock_b, timeout_b};
    endfunction

    task automatic push(input int c, input bit s, input logic [1:0] p,
                        input logic [3:0] d, input logic l,
                        input logic [7:0] r, input logic t);
        exp_t x;
        x.cyc = c;
        x.sel = s;
        x.v   = {p, d, l, r, t};
        sb.push_back(x);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 2'b11;
        push(1, 0, 2'b11, 4'h0, 0, 0, 0);
        push(1, 1, 2'b11, 4'h0, 0, 0, 0);
        push(3, 0, 2'b11, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL reset cyc=%0d dut%0d got=%h exp=%h", i, e.sel, obs(e.sel), e.v);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        push(1,   0, 2'b11, 4'h0, 0, 0, 0);
        push(3,   0, 2'b11, 4'h0, 0, 0, 0);
        push(4,   0, 2'b00, 4'h0, 0, 0, 0);
        push(68,  0, 2'b00, 4'h0, 0, 0, 0);
        push(69,  0, 2'b00, 4'h1, 0, 0, 0);
        push(84,  0, 2'b00, 4'h1, 0, 0, 0);
        push(85,  0, 2'b00, 4'h3, 0, 0, 0);
        push(101, 0, 2'b00, 4'h7, 0, 0, 0);
        push(117, 0, 2'b00, 4'hf, 0, 0, 0);
        push(132, 0, 2'b00, 4'hf, 0, 0, 0);
        push(133, 0, 2'b00, 4'hf, 1, 0, 0);
        for (int i = 1; i <= 140; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL sequence cyc=%0d got=%h exp=%h", i, obs(e.sel), e.v);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sequence_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_filter_restart();
        pll_locked = 2'b11;
        apply_reset();
        push(69,  0, 2'b00, 4'h0, 0, 0, 0);
        push(109, 0, 2'b00, 4'h0, 0, 0, 0);
        push(110, 0, 2'b00, 4'h1, 0, 0, 0);
        push(174, 0, 2'b00, 4'hf, 1, 0, 0);
        for (int i = 1; i <= 180; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL filter cyc=%0d got=%h exp=%h", i, obs(e.sel), e.v);
                end
            end
            if (i == 42) pll_locked = 2'b01;
            if (i == 43) pll_locked = 2'b11;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL filter_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_loss_of_lock();
        pll_locked = 2'b11;
        apply_reset();
        push(140, 0, 2'b00, 4'hf, 1, 0, 0);
        push(147, 0, 2'b00, 4'hf, 1, 0, 0);
        push(148, 0, 2'b11, 4'h0, 0, 1, 0);
        push(151, 0, 2'b11, 4'h0, 0, 1, 0);
        push(152, 0, 2'b00, 4'h0, 0, 1, 0);
        push(216, 0, 2'b00, 4'h0, 0, 1, 0);
        push(217, 0, 2'b00, 4'h1, 0, 1, 0);
        push(281, 0, 2'b00, 4'hf, 1, 1, 0);
        for (int i = 1; i <= 285; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL lock_loss cyc=%0d got=%h exp=%h", i, obs(e.sel), e.v);
                end
            end
            if (i == 145) pll_locked = 2'b10;
            if (i == 146) pll_locked = 2'b11;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL lock_loss_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    // Continues from a locked run with one loss already counted.
    task automatic test_reset_mid_release();
        push(3,  0, 2'b11, 4'h0, 0, 2, 0);
        push(72, 0, 2'b00, 4'h1, 0, 2, 0);
        push(90, 0, 2'b00, 4'h3, 0, 2, 0);
        push(91, 0, 2'b11, 4'h0, 0, 0, 0);
        push(91, 1, 2'b11, 4'h0, 0, 0, 0);
        push(92, 0, 2'b11, 4'h0, 0, 0, 0);
        pll_locked = 2'b10;
        for (int i = 1; i <= 94; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL mid_reset cyc=%0d dut%0d got=%h exp=%h", i, e.sel, obs(e.sel), e.v);
                end
            end
            if (i == 1) pll_locked = 2'b11;
            if (i == 90) rst_n = 1'b0;
            if (i == 92) rst_n = 1'b1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_saturate();
        pll_locked = 2'b11;
        apply_reset();
        push(69,  1, 2'b00, 4'h1, 0, 0, 0);
        push(70,  1, 2'b11, 4'h0, 0, 1, 0);
        push(139, 1, 2'b00, 4'h1, 0, 1, 0);
        push(140, 1, 2'b11, 4'h0, 0, 2, 0);
        push(210, 1, 2'b11, 4'h0, 0, 3, 0);
        push(280, 1, 2'b11, 4'h0, 0, 3, 0);
        push(349, 1, 2'b00, 4'h1, 0, 3, 0);
        push(350, 1, 2'b11, 4'h0, 0, 3, 0);
        for (int i = 1; i <= 355; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL saturate cyc=%0d got=%h exp=%h", i, obs(e.sel), e.v);
                end
            end
            if (i % 70 == 67 && i < 350) pll_locked = 2'b10;
            if (i % 70 == 68) pll_locked = 2'b11;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL saturate_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout();
        pll_locked = 2'b00;
        apply_reset();
`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
        push(103, 1, 2'b00, 4'h0, 0, 0, 0);
        push(104, 1, 2'b11, 4'h0, 0, 1, 1);
        push(105, 1, 2'b11, 4'h0, 0, 1, 0);
        push(108, 1, 2'b00, 4'h0, 0, 1, 0);
        push(207, 1, 2'b00, 4'h0, 0, 1, 0);
        push(208, 1, 2'b11, 4'h0, 0, 2, 1);
        push(312, 1, 2'b11, 4'h0, 0, 3, 1);
        push(416, 1, 2'b11, 4'h0, 0, 3, 1);
`else
        push(5,   1, 2'b00, 4'h0, 0, 0, 0);
        push(104, 1, 2'b00, 4'h0, 0, 0, 0);
        push(208, 1, 2'b00, 4'h0, 0, 0, 0);
        push(416, 1, 2'b00, 4'h0, 0, 0, 0);
`endif
        for (int i = 1; i <= 420; i++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == i) begin
                e = sb.pop_front();
                checks++;
                if (obs(e.sel) !== e.v) begin
                    errors++;
                    $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs(e.sel), e.v);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_filter_restart();
        test_loss_of_lock();
        test_reset_mid_release();
        test_saturate();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
